// File: rtl/pu_or1k_dpram_fifo_ctrl.sv
// pu_or1k_dpram_fifo_ctrl
//   FIFO controller in front of a single-clock true dual-port RAM.
//   Port A is the write side and port B is the read side.
//   Reads are issued ahead of demand. The RAM's 1-cycle read latency is absorbed
//   by a 2-entry output stage (out + skid). As a result, rd_data is registered and
//   first-word-fall-through, and the FIFO sustains one word per cycle.
//
// Ports
//   clk, rst             single clock; synchronous active-high reset
//   wr_valid/ready/data  producer side; a transfer happens on wr_valid && wr_ready
//   rd_valid/ready/data  consumer side; a pop happens on rd_valid && rd_ready
//   ram_*_a              RAM port A (write only)
//   ram_*_b, ram_dout_b  RAM port B (read only); ram_dout_b is valid one cycle after the address
//
// Optional feature: define PU_OR1K_FIFO_LEVEL_EN to add the outputs
//   level       = total words held (RAM + in-flight read + output stage), registered
//   almost_full = RAM holds DEPTH-1 or more words
module pu_or1k_dpram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic                  ram_we_a,
  output logic [DATA_WIDTH-1:0] ram_din_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic                  ram_we_b,
  output logic [DATA_WIDTH-1:0] ram_din_b,
  input  logic [DATA_WIDTH-1:0] ram_dout_b
`ifdef PU_OR1K_FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  almost_full
`endif
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

  // Pointers carry one extra wrap bit, so full (DEPTH) and empty (0) are distinguishable.
  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr, mem_cnt;
  logic                  pend;      // a RAM read was issued last cycle
  logic [1:0]            hold_cnt;  // occupied entries of out/skid
  logic [DATA_WIDTH-1:0] out_q, skid_q;
  logic                  wr_fire, pop, iss;
  logic [2:0]            stage_need;

  assign mem_cnt  = wr_ptr - rd_ptr;
  assign wr_ready = !rst && (mem_cnt != DEPTH_C);
  assign wr_fire  = wr_valid && wr_ready;
  assign rd_valid = (hold_cnt != 2'd0);
  assign rd_data  = out_q;
  assign pop      = rd_valid && rd_ready;

  // Output-stage occupancy next cycle if no new read were issued now.
  // A read is issued only if its data will still have a slot when it lands.
  // pop implies hold_cnt >= 1, so the subtraction cannot underflow.
  assign stage_need = {1'b0, hold_cnt} + {2'b00, pend} - {2'b00, pop};
  assign iss        = (mem_cnt != '0) && (stage_need < 3'd2);

  assign ram_addr_a = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_we_a   = wr_fire;
  assign ram_din_a  = wr_data;
  assign ram_addr_b = rd_ptr[ADDR_WIDTH-1:0];
  assign ram_we_b   = 1'b0;
  assign ram_din_b  = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pend     <= 1'b0;
      hold_cnt <= 2'd0;
      out_q    <= '0;
      skid_q   <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (iss)     rd_ptr <= rd_ptr + 1'b1;
      pend     <= iss;
      hold_cnt <= stage_need[1:0];
      // The skid word always drains into out first, so ordering stays FIFO.
      if (pop && hold_cnt == 2'd2)
        out_q <= skid_q;
      else if (pend && (hold_cnt == 2'd0 || pop))
        out_q <= ram_dout_b;
      // The arriving word parks in skid when out stays occupied after this edge.
      if (pend && ((hold_cnt == 2'd1 && !pop) || (hold_cnt == 2'd2 && pop)))
        skid_q <= ram_dout_b;
    end
  end

`ifdef PU_OR1K_FIFO_LEVEL_EN
  logic [ADDR_WIDTH+1:0] level_nxt;
  assign level_nxt = {1'b0, mem_cnt} + {{(ADDR_WIDTH+1){1'b0}}, wr_fire}
                   - {{(ADDR_WIDTH+1){1'b0}}, iss} + {{(ADDR_WIDTH+1){1'b0}}, iss}
                   + {{ADDR_WIDTH{1'b0}}, stage_need[1:0]};

  // level reflects the occupancy after each edge: RAM + pending read + stage.
  always_ff @(posedge clk) begin
    if (rst) level <= '0;
    else     level <= level_nxt;
  end

  assign almost_full = ({1'b0, mem_cnt} >= {1'b0, DEPTH_C} - 1'b1);
`endif

endmodule

// File: tb/tb_pu_or1k_dpram_fifo_ctrl.sv
// Directed bench for pu_or1k_dpram_fifo_ctrl (AW=2, DEPTH=4, DW=32) with a behavioural RAM.
module tb_pu_or1k_dpram_fifo_ctrl;
  localparam int AW = 2;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid, wr_ready, rd_valid, rd_ready;
  logic [DW-1:0] wr_data, rd_data;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic          ram_we_a, ram_we_b;
  logic [DW-1:0] ram_din_a, ram_din_b, ram_dout_b;
`ifdef PU_OR1K_FIFO_LEVEL_EN
  logic [AW+1:0] level;
  logic          almost_full;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pu_or1k_dpram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .ram_addr_a(ram_addr_a), .ram_we_a(ram_we_a), .ram_din_a(ram_din_a),
    .ram_addr_b(ram_addr_b), .ram_we_b(ram_we_b), .ram_din_b(ram_din_b),
    .ram_dout_b(ram_dout_b)
`ifdef PU_OR1K_FIFO_LEVEL_EN
    , .level(level), .almost_full(almost_full)
`endif
  );

  // Behavioural single-clock dual-port RAM with a 1-cycle read latency.
  logic [DW-1:0] ram [4];
  always @(posedge clk) begin
    if (ram_we_a) ram[ram_addr_a] <= ram_din_a;
    ram_dout_b <= ram[ram_addr_b];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_w, prev_data;
    int acc, got, sent, cyc;
    logic prev_stall;

    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    tick();
    #1;
    chk("rst_wr_ready", wr_ready, 0);
    tick();
    rst = 1'b0;
    #1;

    // Idle after reset.
    for (int i = 0; i < 3; i++) begin
      chk("idle_rd_valid", rd_valid, 0);
      chk("idle_wr_ready", wr_ready, 1);
      chk("idle_we_a", ram_we_a, 0);
      chk("idle_we_b", ram_we_b, 0);
      chk("idle_din_b", ram_din_b, 0);
`ifdef PU_OR1K_FIFO_LEVEL_EN
      chk("idle_level", level, 0);
`endif
      tick();
    end

    // Single word: accepted in cycle 0, visible in cycle 3, gone in cycle 4.
    wr_valid = 1'b1; wr_data = 32'hA5A5_0001; rd_ready = 1'b1;
    #1;
    chk("single_we_a", ram_we_a, 1);
    chk("single_addr_a", ram_addr_a, 0);
    chk("single_din_a", ram_din_a, 32'hA5A5_0001);
    tick();
    wr_valid = 1'b0;
    #1;
    chk("single_c1_vld", rd_valid, 0);
    chk("single_c1_addr_b", ram_addr_b, 0);
    tick();
    chk("single_c2_vld", rd_valid, 0);
    tick();
    chk("single_c3_vld", rd_valid, 1);
    chk("single_c3_data", rd_data, 32'hA5A5_0001);
    tick();
    chk("single_c4_vld", rd_valid, 0);

    // Fill with the consumer stalled: DEPTH + 2 = 6 words fit.
    rd_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      wr_valid = 1'b1; wr_data = 32'h10 + acc;
      #1;
      if (wr_ready) acc++;
      tick();
    end
    wr_valid = 1'b0;
    #1;
    chk("fill_accepted", acc, 6);
    chk("fill_wr_ready", wr_ready, 0);
    chk("fill_rd_valid", rd_valid, 1);
    chk("fill_head", rd_data, 32'h10);
`ifdef PU_OR1K_FIFO_LEVEL_EN
    chk("fill_level", level, 6);
    chk("fill_almost_full", almost_full, 1);
`endif
    rd_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && got < 6; i++) begin
      #1;
      if (rd_valid) begin
        chk("drain_data", rd_data, 32'h10 + got);
        got++;
      end
      tick();
    end
    chk("drain_count", got, 6);
    tick();
    chk("drain_empty", rd_valid, 0);

    // Streaming; both pointers sit at 7, so the low address bits start at 3 and wrap to 0.
    for (int i = 0; i < 20; i++) begin
      wr_valid = 1'b1; wr_data = 32'h100 + i; rd_ready = 1'b1;
      #1;
      chk("stream_addr_a", ram_addr_a, (3 + i) & 3);
      chk("stream_addr_b", ram_addr_b, (i == 0) ? 3 : ((3 + i - 1) & 3));
      chk("stream_wr_ready", wr_ready, 1);
      if (i >= 3) begin
        chk("stream_vld", rd_valid, 1);
        chk("stream_data", rd_data, 32'h100 + i - 3);
      end else begin
        chk("stream_fill_vld", rd_valid, 0);
      end
      tick();
    end
    wr_valid = 1'b0;
    for (int i = 20; i < 23; i++) begin
      #1;
      chk("stream_tail_vld", rd_valid, 1);
      chk("stream_tail_data", rd_data, 32'h100 + i - 3);
      tick();
    end
    chk("stream_end_vld", rd_valid, 0);

    // Random traffic with consumer stalls and a scoreboard.
    sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
    while (got < 1000 && cyc < 20000) begin
      wr_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
      wr_data  = 32'hC000_0000 + sent;
      rd_ready = $urandom_range(0, 1) != 0;
      #1;
      if (prev_stall) begin
        chk("stall_vld", rd_valid, 1);
        chk("stall_data", rd_data, prev_data);
      end
      if (wr_valid && wr_ready) begin
        q.push_back(wr_data);
        sent++;
      end
      if (rd_valid && rd_ready) begin
        if (q.size() == 0) begin
          chk("rand_underflow", rd_valid, 0);
        end else begin
          exp_w = q.pop_front();
          chk("rand_data", rd_data, exp_w);
        end
        got++;
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
      tick();
      cyc++;
    end
    chk("rand_count", got, 1000);
    wr_valid = 1'b0; rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("rand_empty", rd_valid, 0);

    // Reset while 5 words are held.
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_data = 32'h20 + i;
      tick();
    end
    wr_valid = 1'b0;
    tick();
    tick();
    chk("held_vld", rd_valid, 1);
    chk("held_head", rd_data, 32'h20);
`ifdef PU_OR1K_FIFO_LEVEL_EN
    chk("held_level", level, 5);
`endif
    rst = 1'b1;
    #1;
    chk("mid_rst_wr_ready", wr_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_vld", rd_valid, 0);
    chk("post_rst_wr_ready", wr_ready, 1);
`ifdef PU_OR1K_FIFO_LEVEL_EN
    chk("post_rst_level", level, 0);
`endif
    wr_valid = 1'b1; wr_data = 32'hBEEF_0030; rd_ready = 1'b1;
    tick();
    wr_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      #1;
      if (rd_valid) begin
        chk("post_rst_data", rd_data, 32'hBEEF_0030);
        got = 1;
      end
      tick();
    end
    chk("post_rst_seen", got, 1);
    chk("post_rst_empty", rd_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
